// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder:
// MMIO word offsets, region decode, byte-enable patterns, store-data steering.
package dmem_pkg;

  localparam int unsigned OFF_W = 10;

  // Word offsets (a[11:2]) inside the register block
  localparam logic [OFF_W-1:0] OFF_CYC_LO = 10'h000;
  localparam logic [OFF_W-1:0] OFF_CYC_HI = 10'h001;
  localparam logic [OFF_W-1:0] OFF_GPIO   = 10'h002;
  localparam logic [OFF_W-1:0] OFF_TCMP   = 10'h003;
  localparam logic [OFF_W-1:0] OFF_TSTAT  = 10'h004;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Byte-enable patterns recognised by the store steering
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Core issues unshifted rs2: replicate byte/half so every lane sees it
  function automatic logic [31:0] steer_wdata(input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] s;
    s = wd;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: s = {4{wd[7:0]}};
      BE_HALF_LO, BE_HALF_HI:     s = {2{wd[15:0]}};
      default:                    s = wd;
    endcase
    return s;
  endfunction

  // Merge new lanes into an old word under byte enables
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Region from the upper address page (a[31:12]); RAM takes precedence
  function automatic region_e decode_region(input logic [19:0] page,
                                            input logic [19:0] mmio_page);
    region_e r;
    r = REG_NONE;
    if (page[19:16] == 4'h0)    r = REG_RAM;
    else if (page == mmio_page) r = REG_MMIO;
    return r;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped register block: 64-bit cycle counter, GPIO output register
// and, when DMEM_TIMER_EN is defined, timer compare plus sticky match flag.
module mmio_regs
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] offset,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata,
  output logic [31:0]      gpio_out,
  output logic             timer_irq
);

  logic [63:0] cyc_q, cyc_d;
  logic [31:0] gpio_q, gpio_d;

  // Counter increment and GPIO lane writes; reset beats both
  always_comb begin
    cyc_d  = cyc_q + 64'd1;
    gpio_d = gpio_q;
    if (wr_en && offset == OFF_GPIO) gpio_d = lane_merge(gpio_q, wdata, be);
    if (clr) begin
      cyc_d  = '0;
      gpio_d = '0;
    end
  end

  // Counter and GPIO state
  always_ff @(posedge clk) begin
    cyc_q  <= cyc_d;
    gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] tcmp_q, tcmp_d;
  logic        flag_q, flag_d;

  // Compare register writes, W1C on lane 0, match set wins over clear
  always_comb begin
    tcmp_d = tcmp_q;
    flag_d = flag_q;
    if (wr_en && offset == OFF_TCMP) tcmp_d = lane_merge(tcmp_q, wdata, be);
    if (wr_en && offset == OFF_TSTAT && be[0] && wdata[0]) flag_d = 1'b0;
    if (tcmp_q != 32'd0 && cyc_q[31:0] == tcmp_q) flag_d = 1'b1;
    if (clr) begin
      tcmp_d = '0;
      flag_d = 1'b0;
    end
  end

  // Timer state
  always_ff @(posedge clk) begin
    tcmp_q <= tcmp_d;
    flag_q <= flag_d;
  end

  assign timer_irq = flag_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Register read mux on the pre-edge state
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CYC_LO: rdata = cyc_q[31:0];
      OFF_CYC_HI: rdata = cyc_q[63:32];
      OFF_GPIO:   rdata = gpio_q;
`ifdef DMEM_TIMER_EN
      OFF_TCMP:   rdata = tcmp_q;
      OFF_TSTAT:  rdata = {31'd0, flag_q};
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: address decode, store lane steering,
// word RAM with byte-lane writes and the mmio_regs block.
// Optional timer compare/IRQ enabled by defining DMEM_TIMER_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [3:0]  byteEnable,
  output logic [31:0] rd,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  // RAM contents survive clr, so the array carries no reset
  logic [31:0] ram_q [DEPTH_WORDS];

  region_e          region_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      wd_steer_c;
  logic             ram_we_c;
  logic             mmio_we_c;
  logic [31:0]      mmio_rdata;
  logic             unused_addr;

  // Byte offset within the word is resolved by the core's load extender
  assign unused_addr = ^a[1:0];

  // Decode region, RAM index and steered store data
  always_comb begin
    region_c   = decode_region(a[31:12], MMIO_BASE[31:12]);
    idx_c      = a[IDX_W+1:2];
    wd_steer_c = steer_wdata(wd, byteEnable);
    ram_we_c   = we && (region_c == REG_RAM)  && (byteEnable != BE_NONE);
    mmio_we_c  = we && (region_c == REG_MMIO) && (byteEnable != BE_NONE);
  end

  // RAM byte-lane write; reads see the pre-edge word
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_q[idx_c] <= lane_merge(ram_q[idx_c], wd_steer_c, byteEnable);
  end

  mmio_regs u_mmio (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (mmio_we_c),
    .offset    (a[11:2]),
    .wdata     (wd_steer_c),
    .be        (byteEnable),
    .rdata     (mmio_rdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  // Combinational read return
  always_comb begin
    rd = '0;
    case (region_c)
      REG_RAM:  rd = ram_q[idx_c];
      REG_MMIO: rd = mmio_rdata;
      default:  rd = '0;
    endcase
  end

endmodule
